// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared SLL/SRL/SRA shifter.
// One registered result slot, tagged with the owner, held under backpressure.
module shift_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_data
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_grant;
  logic               r_resp_id;
  logic [WIDTH-1:0]   r_resp_data;

  logic               w_slot_free;
  logic               w_gnt_valid;
  logic               w_gnt_id;
  logic               w_accept;
  logic [WIDTH-1:0]   w_a;
  logic [SHAMT_W-1:0] w_shamt;
  logic [1:0]         w_op;
  logic [WIDTH-1:0]   w_shift;

  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0]   a,
    input logic [SHAMT_W-1:0] sh,
    input logic [1:0]         op
  );
    logic signed [WIDTH-1:0] s;
    s = a;
    case (op)
      2'b00:   f_shift = a << sh;
      2'b01:   f_shift = a >> sh;
      2'b10:   f_shift = $unsigned(s >>> sh);
      default: f_shift = a;
    endcase
  endfunction

  // Both valid: the port that did not win last time gets the grant.
  always_comb begin
    w_gnt_valid = req0_valid | req1_valid;
    w_gnt_id    = 1'b0;
    if (req0_valid && req1_valid)
      w_gnt_id = ~r_last_grant;
    else if (req1_valid)
      w_gnt_id = 1'b1;
  end

  assign w_slot_free = (r_state == IDLE) | resp_ready;
  assign w_accept    = w_gnt_valid & w_slot_free & ~reset;
  assign req0_ready  = w_accept & ~w_gnt_id;
  assign req1_ready  = w_accept &  w_gnt_id;

  assign w_a     = w_gnt_id ? req1_a     : req0_a;
  assign w_shamt = w_gnt_id ? req1_shamt : req0_shamt;
  assign w_op    = w_gnt_id ? req1_op    : req0_op;
  assign w_shift = f_shift(w_a, w_shamt, w_op);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = HOLD;
      HOLD:    if (resp_ready && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result register stage: accept at edge k, visible after edge k.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_resp_data  <= w_shift;
        r_resp_id    <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
    end
  end

  assign resp_valid = (r_state == HOLD);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, single requests, contention,
// backpressure, SLL sweep, pass-through and reset while holding a result.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a;
  logic [4:0]  req0_shamt;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a;
  logic [4:0]  req1_shamt;
  logic [1:0]  req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_shamt = '0; req0_op = 2'b00;
    req1_valid = 1'b0; req1_a = '0; req1_shamt = '0; req1_op = 2'b00;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_data",  resp_data,  0);
    chk("rst_id",    resp_id,    0);

    // req0 alone: 1 << 31
    req0_valid = 1'b1; req0_a = 32'h1; req0_shamt = 5'd31; req0_op = 2'b00;
    #1;
    chk("r0_alone_rdy0", req0_ready, 1);
    chk("r0_alone_rdy1", req1_ready, 0);
    tick();
    chk("r0_alone_vld",  resp_valid, 1);
    chk("r0_alone_id",   resp_id,    0);
    chk("r0_alone_data", resp_data,  32'h8000_0000);

    // req1 alone pass-through, shamt ignored
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hDEAD_BEEF; req1_shamt = 5'd7; req1_op = 2'b11;
    #1;
    chk("pass_rdy1", req1_ready, 1);
    tick();
    chk("pass_id",   resp_id,   1);
    chk("pass_data", resp_data, 32'hDEAD_BEEF);

    // Contention: req0 SRA, req1 SRL, both shamt 4; expect 0,1,0,1
    req0_valid = 1'b1; req0_a = 32'hF000_0000; req0_shamt = 5'd4; req0_op = 2'b10;
    req1_valid = 1'b1; req1_a = 32'hF000_0000; req1_shamt = 5'd4; req1_op = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("cont_vld",  resp_valid, 1);
      chk("cont_id",   resp_id,    (i % 2 == 0) ? 0 : 1);
      chk("cont_data", resp_data,  (i % 2 == 0) ? 32'hFF00_0000 : 32'h0F00_0000);
    end

    // Backpressure for 3 cycles with req1 waiting
    req0_valid = 1'b0;
    req1_a = 32'h0000_0080; req1_shamt = 5'd3; req1_op = 2'b01;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy0", req0_ready, 0);
      chk("bp_rdy1", req1_ready, 0);
      tick();
      chk("bp_vld",  resp_valid, 1);
      chk("bp_id",   resp_id,    1);
      chk("bp_data", resp_data,  32'h0F00_0000);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_rdy1", req1_ready, 1);
    tick();
    chk("bp_release_id",   resp_id,   1);
    chk("bp_release_data", resp_data, 32'h0000_0010);

    // SLL sweep on req1, a=1
    req1_a = 32'h1; req1_op = 2'b00;
    for (int s = 0; s < 32; s++) begin
      req1_shamt = 5'(s);
      tick();
      chk("sll_sweep", resp_data, 32'h1 << s);
    end
    req1_valid = 1'b0;
    tick();
    chk("drain_vld", resp_valid, 0);

    // Enter HOLD via req0 (so last grant = 0), stall, then reset with req1 waiting
    req0_valid = 1'b1; req0_a = 32'h0000_00F0; req0_shamt = 5'd4; req0_op = 2'b00;
    tick();
    chk("hold_data", resp_data, 32'h0000_0F00);
    req0_valid = 1'b0; resp_ready = 1'b0; req1_valid = 1'b1;
    tick();
    chk("hold_vld", resp_valid, 1);
    reset = 1'b1; resp_ready = 1'b1;
    #1;
    chk("rst_hold_rdy0", req0_ready, 0);
    chk("rst_hold_rdy1", req1_ready, 0);
    tick();
    chk("rst_hold_vld",  resp_valid, 0);
    chk("rst_hold_data", resp_data,  0);
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'hF000_0000; req0_shamt = 5'd4; req0_op = 2'b10;
    #1;
    chk("post_rst_rdy0", req0_ready, 1);
    chk("post_rst_rdy1", req1_ready, 0);
    tick();
    chk("post_rst_id",   resp_id,   0);
    chk("post_rst_data", resp_data, 32'hFF00_0000);

    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
